// File: rtl/game_tick_scheduler.sv
// game_tick_scheduler: game FSM (IDLE/PLAY/PAUSE/OVER), score-rate prescaler, BCD score with
// level tracking, and an obstacle spawn scheduler whose gap shrinks as the level rises.
// Optional feature macro: HISCORE_EN adds a best-score register and the hiscore_bcd output.
module game_tick_scheduler #(
    parameter int unsigned CLK_HZ   = 27000000,
    parameter int unsigned SCORE_HZ = 9,
    parameter int unsigned BASE_GAP = 16,
    parameter int unsigned MIN_GAP  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        pause,
    input  logic        collision,
    output logic        score_tick,
    output logic        obstacle_tick,
    output logic [15:0] score_bcd,
    output logic [2:0]  level,
    output logic [1:0]  state,
    output logic        game_over
`ifdef HISCORE_EN
    ,
    output logic [15:0] hiscore_bcd
`endif
);

    localparam int unsigned DIV = CLK_HZ / SCORE_HZ;
    localparam int unsigned PW  = $clog2(DIV);
    localparam int unsigned GW  = $clog2(BASE_GAP + 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StPlay  = 2'd1,
        StPause = 2'd2,
        StOver  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [15:0]     score_q, score_d;
    logic [2:0]      level_q, level_d;
    logic            score_tick_q, score_tick_d;
    logic            obstacle_tick_q, obstacle_tick_d;
    logic            game_over_q, game_over_d;
    int              gap_target;

    // BCD +1 with per-digit carry; caller handles saturation at 9999.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Spawn gap for the current (pre-update) level, floored at MIN_GAP.
    always_comb begin
        gap_target = int'(BASE_GAP) - 2 * int'(level_q);
        if (gap_target < int'(MIN_GAP)) begin
            gap_target = int'(MIN_GAP);
        end
    end

    // Next-state: FSM transitions, prescaler, score/level and spawn scheduling.
    always_comb begin
        state_d         = state_q;
        pre_d           = pre_q;
        gap_d           = gap_q;
        score_d         = score_q;
        level_d         = level_q;
        score_tick_d    = 1'b0;
        obstacle_tick_d = 1'b0;
        unique case (state_q)
            StIdle, StOver: begin
                if (start) begin
                    state_d = StPlay;
                    pre_d   = '0;
                    gap_d   = '0;
                    score_d = '0;
                    level_d = '0;
                end
            end
            StPlay: begin
                if (collision) begin
                    // Collision wins over a coincident terminal count: no tick, score frozen.
                    state_d = StOver;
                end else begin
                    if (pause) begin
                        state_d = StPause;
                    end
                    if (pre_q == PW'(DIV - 1)) begin
                        // Entering PAUSE at terminal count holds DIV-1 so the tick fires on resume.
                        if (!pause) begin
                            pre_d        = '0;
                            score_tick_d = 1'b1;
                            if (score_q != 16'h9999) begin
                                score_d = bcd_inc(score_q);
                                if (score_q[7:0] == 8'h99 && level_q != 3'd7) begin
                                    level_d = level_q + 3'd1;
                                end
                            end
                            // >= also catches a counter left above a target that just shrank.
                            if (int'(gap_q) >= gap_target - 1) begin
                                obstacle_tick_d = 1'b1;
                                gap_d           = '0;
                            end else begin
                                gap_d = gap_q + GW'(1);
                            end
                        end
                    end else begin
                        pre_d = pre_q + PW'(1);
                    end
                end
            end
            StPause: begin
                if (!pause) begin
                    state_d = StPlay;
                end
            end
            default: state_d = StIdle;
        endcase
        game_over_d = (state_d == StOver);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            pre_q           <= '0;
            gap_q           <= '0;
            score_q         <= '0;
            level_q         <= '0;
            score_tick_q    <= 1'b0;
            obstacle_tick_q <= 1'b0;
            game_over_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            pre_q           <= pre_d;
            gap_q           <= gap_d;
            score_q         <= score_d;
            level_q         <= level_d;
            score_tick_q    <= score_tick_d;
            obstacle_tick_q <= obstacle_tick_d;
            game_over_q     <= game_over_d;
        end
    end

    assign score_tick    = score_tick_q;
    assign obstacle_tick = obstacle_tick_q;
    assign score_bcd     = score_q;
    assign level         = level_q;
    assign state         = state_q;
    assign game_over     = game_over_q;

`ifdef HISCORE_EN
    logic [15:0] hiscore_q, hiscore_d;

    // Capture a new best score on the PLAY->OVER edge; BCD orders like binary.
    always_comb begin
        hiscore_d = hiscore_q;
        if (state_q == StPlay && state_d == StOver && score_q > hiscore_q) begin
            hiscore_d = score_q;
        end
    end

    // Best-score register; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hiscore_q <= '0;
        end else begin
            hiscore_q <= hiscore_d;
        end
    end

    assign hiscore_bcd = hiscore_q;
`endif

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Bench for game_tick_scheduler: main instance at DIV=10, fast instance at DIV=2 for saturation.
module tb_game_tick_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, pause, collision;
    logic        score_tick, obstacle_tick, game_over;
    logic [15:0] score_bcd;
    logic [2:0]  level;
    logic [1:0]  state;
    logic        f_start;
    logic        f_score_tick, f_obstacle_tick, f_game_over;
    logic [15:0] f_score_bcd;
    logic [2:0]  f_level;
    logic [1:0]  f_state;
`ifdef HISCORE_EN
    logic [15:0] hiscore_bcd, f_hiscore_bcd;
`endif

    always #5 clk = ~clk;

    game_tick_scheduler #(
        .CLK_HZ(90), .SCORE_HZ(9), .BASE_GAP(4), .MIN_GAP(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .collision(collision),
        .score_tick(score_tick), .obstacle_tick(obstacle_tick), .score_bcd(score_bcd),
        .level(level), .state(state), .game_over(game_over)
`ifdef HISCORE_EN
        , .hiscore_bcd(hiscore_bcd)
`endif
    );

    game_tick_scheduler #(
        .CLK_HZ(18), .SCORE_HZ(9), .BASE_GAP(4), .MIN_GAP(2)
    ) dut_fast (
        .clk(clk), .rst_n(rst_n), .start(f_start), .pause(1'b0), .collision(1'b0),
        .score_tick(f_score_tick), .obstacle_tick(f_obstacle_tick), .score_bcd(f_score_bcd),
        .level(f_level), .state(f_state), .game_over(f_game_over)
`ifdef HISCORE_EN
        , .hiscore_bcd(f_hiscore_bcd)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [15:0] score;
        logic [2:0]  level;
        logic        obs;
    } exp_t;

    exp_t exp_q[$];
    int   m_score, m_level, m_gap;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic model_reset();
        m_score = 0;
        m_level = 0;
        m_gap   = 0;
    endtask

    // Push the expected result of the next n score ticks.
    task automatic push_ticks(input int n);
        int   tgt;
        exp_t e;
        for (int i = 0; i < n; i++) begin
            tgt = 4 - 2 * m_level;
            if (tgt < 2) tgt = 2;
            e.obs = (m_gap == tgt - 1);
            m_gap = e.obs ? 0 : m_gap + 1;
            if (m_score < 9999) begin
                if (m_score % 100 == 99 && m_level < 7) m_level++;
                m_score++;
            end
            e.score = to_bcd(m_score);
            e.level = 3'(m_level);
            exp_q.push_back(e);
        end
    endtask

    // Scoreboard: every score tick pops one expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (score_tick) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_tick", {31'b0, score_tick}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_eq("tick_score", {16'b0, score_bcd}, {16'b0, e.score});
                    check_eq("tick_level", {29'b0, level}, {29'b0, e.level});
                    check_eq("tick_obstacle", {31'b0, obstacle_tick}, {31'b0, e.obs});
                end
            end else if (obstacle_tick) begin
                check_eq("lone_obstacle", {31'b0, obstacle_tick}, 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Cycles from now until the next score_tick edge, bounded.
    task automatic wait_tick(output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (!score_tick && cycles < 100);
    endtask

    task automatic run_ticks(input int n, input string tag);
        int c;
        for (int i = 0; i < n; i++) begin
            wait_tick(c);
            check_eq(tag, c, 10);
        end
    endtask

    initial begin
        int c, cnt;
        rst_n = 1'b0; start = 1'b0; pause = 1'b0; collision = 1'b0; f_start = 1'b0;
        step();
        // 1: start ignored under reset
        pulse_start();
        check_eq("rst_state", {30'b0, state}, 32'd0);
        check_eq("rst_score", {16'b0, score_bcd}, 32'd0);
        check_eq("rst_level", {29'b0, level}, 32'd0);
        check_eq("rst_ticks", {30'b0, score_tick, obstacle_tick}, 32'd0);
        check_eq("rst_game_over", {31'b0, game_over}, 32'd0);
`ifdef HISCORE_EN
        check_eq("rst_hiscore", {16'b0, hiscore_bcd}, 32'd0);
`endif
        rst_n = 1'b1;
        step();
        model_reset();
        push_ticks(12);
        pulse_start();
        check_eq("play_state", {30'b0, state}, 32'd1);
        wait_tick(c);
        check_eq("first_tick_latency", c, 10);
        // 1+2: regular period; obstacles on every 4th tick via scoreboard
        run_ticks(11, "tick_period");

        // 3: pause raised while prescaler is 5
        repeat (5) step();
        pause = 1'b1;
        step();
        check_eq("pause_state", {30'b0, state}, 32'd2);
        collision = 1'b1;
        step();
        collision = 1'b0;
        check_eq("pause_ignores_collision", {30'b0, state}, 32'd2);
        cnt = 0;
        for (int i = 0; i < 35; i++) begin
            step();
            if (score_tick || obstacle_tick) cnt++;
        end
        check_eq("pause_no_pulses", cnt, 0);
        check_eq("pause_score_held", {16'b0, score_bcd}, 32'h0012);
        push_ticks(1);
        pause = 1'b0;
        step();
        check_eq("resume_state", {30'b0, state}, 32'd1);
        wait_tick(c);
        check_eq("resume_latency", c, 4);

        // 4: through 0099 -> 0100, level 1, gap 2
        push_ticks(91);
        run_ticks(91, "long_period");
        check_eq("score_0104", {16'b0, score_bcd}, 32'h0104);
        check_eq("level_1", {29'b0, level}, 32'd1);

        // 5: collision on terminal count
        repeat (9) step();
        collision = 1'b1;
        step();
        collision = 1'b0;
        check_eq("over_state", {30'b0, state}, 32'd3);
        check_eq("over_game_over", {31'b0, game_over}, 32'd1);
        check_eq("over_no_tick", {31'b0, score_tick}, 32'd0);
        check_eq("over_score", {16'b0, score_bcd}, 32'h0104);
`ifdef HISCORE_EN
        check_eq("hiscore_game1", {16'b0, hiscore_bcd}, 32'h0104);
`endif
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (score_tick || obstacle_tick) cnt++;
        end
        check_eq("over_no_pulses", cnt, 0);

        // Game 2: start clears; start during PLAY ignored
        model_reset();
        push_ticks(7);
        pulse_start();
        check_eq("restart_state", {30'b0, state}, 32'd1);
        check_eq("restart_score", {16'b0, score_bcd}, 32'd0);
        check_eq("restart_level", {29'b0, level}, 32'd0);
        check_eq("restart_game_over", {31'b0, game_over}, 32'd0);
        run_ticks(3, "g2_period");
        pulse_start();
        wait_tick(c);
        check_eq("start_ignored_latency", c, 9);
        run_ticks(3, "g2_period");
        collision = 1'b1;
        step();
        collision = 1'b0;
        check_eq("g2_over_state", {30'b0, state}, 32'd3);
        check_eq("g2_score", {16'b0, score_bcd}, 32'h0007);
`ifdef HISCORE_EN
        check_eq("hiscore_kept", {16'b0, hiscore_bcd}, 32'h0104);
`endif

        // Mid-game asynchronous reset
        model_reset();
        push_ticks(2);
        pulse_start();
        run_ticks(2, "g3_period");
        repeat (3) step();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_state", {30'b0, state}, 32'd0);
        check_eq("async_rst_score", {16'b0, score_bcd}, 32'd0);
`ifdef HISCORE_EN
        check_eq("async_rst_hiscore", {16'b0, hiscore_bcd}, 32'd0);
`endif
        step();
        rst_n = 1'b1;
        step();
        check_eq("queue_drained", exp_q.size(), 0);

        // Saturation on the fast instance (DIV=2)
        f_start = 1'b1;
        step();
        f_start = 1'b0;
        cnt = 0;
        c = 0;
        while (cnt < 9999 && c < 30000) begin
            step();
            c++;
            if (f_score_tick) cnt++;
        end
        check_eq("fast_tick_count", cnt, 9999);
        check_eq("sat_score", {16'b0, f_score_bcd}, 32'h9999);
        check_eq("sat_level", {29'b0, f_level}, 32'd7);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (f_score_tick) cnt++;
        end
        check_eq("sat_ticks_continue", cnt, 3);
        check_eq("sat_score_held", {16'b0, f_score_bcd}, 32'h9999);
        check_eq("sat_level_held", {29'b0, f_level}, 32'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
